// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory req/ack bus between the MEM stage (master) and memory (slave)
interface mem_stage_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [3:0]       mem_be;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;
  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with req/ack loads/stores, stall, timeout BusErr; optional MEM_ALIGN_CHECK_EN
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef NOP
`define NOP 6'h00
`endif
`ifndef LW
`define LW 6'h23
`endif
`ifndef LH
`define LH 6'h21
`endif
`ifndef LD
`define LD 6'h20
`endif
`ifndef SW
`define SW 6'h2B
`endif
`ifndef SH
`define SH 6'h29
`endif
`ifndef SD
`define SD 6'h28
`endif

module mem_stage #(
  parameter int WIDTH       = `WIDTH,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] IR_in,
  input  logic [WIDTH-3:0] PC_in,
  input  logic [WIDTH-1:0] Z_in,
  input  logic [WIDTH-1:0] Addr_in,
  output logic             IsStall,
  output logic [WIDTH-1:0] IR_out,
  output logic [WIDTH-3:0] PC_out,
  output logic [WIDTH-1:0] Z_out,
  output logic [WIDTH-1:0] LMD,
  output logic             BusErr,
  mem_stage_if.master      bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [5:0] OP_NOP = `NOP;
  localparam logic [5:0] OP_LW  = `LW;
  localparam logic [5:0] OP_LH  = `LH;
  localparam logic [5:0] OP_LD  = `LD;
  localparam logic [5:0] OP_SW  = `SW;
  localparam logic [5:0] OP_SH  = `SH;
  localparam logic [5:0] OP_SD  = `SD;
  localparam logic [WIDTH-1:0] NOP_IR = {OP_NOP, {(WIDTH-6){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ir_q, z_q, addr_q, lmd_q, load_ext;
  logic [WIDTH-3:0] pc_q;
  logic [7:0]       cnt_q;
  logic [5:0]       op_in, op_q;
  logic [15:0]      half_lane;
  logic [7:0]       byte_lane;
  logic             berr_q, err_d, in_mem, q_mem, in_bad, q_bad;
  logic             accept, timeout, acc, is_load, is_store, is_word, is_half, is_byte;

  function automatic logic is_mem_op(input logic [5:0] op);
    return op inside {OP_LW, OP_LH, OP_LD, OP_SW, OP_SH, OP_SD};
  endfunction

  assign op_in  = IR_in[WIDTH-1 -: 6];
  assign op_q   = ir_q[WIDTH-1 -: 6];
  assign in_mem = is_mem_op(op_in);
  assign q_mem  = is_mem_op(op_q);

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
    return ((op == OP_LW || op == OP_SW) && a != 2'b00) || ((op == OP_LH || op == OP_SH) && a[0]);
  endfunction
  assign in_bad = misaligned(op_in, Addr_in[1:0]);
  assign q_bad  = misaligned(op_q, addr_q[1:0]);
`else
  assign in_bad = 1'b0;
  assign q_bad  = 1'b0;
`endif

  assign acc      = state_q == ACCESS;
  assign is_word  = op_q == OP_LW || op_q == OP_SW;
  assign is_half  = op_q == OP_LH || op_q == OP_SH;
  assign is_byte  = op_q == OP_LD || op_q == OP_SD;
  assign is_load  = op_q inside {OP_LW, OP_LH, OP_LD};
  assign is_store = op_q inside {OP_SW, OP_SH, OP_SD};
  // Last ACCESS cycle without an ack; an ack in this same cycle takes priority.
  assign timeout  = acc && !bus.mem_ack && cnt_q == 8'(ACK_TIMEOUT - 1);
  // A new EXE result is taken in IDLE (unless a memory op is still waiting to start) and in DONE.
  assign accept   = (state_q == IDLE && !q_mem) || state_q == DONE;
  assign err_d    = (state_q == IDLE && (q_mem ? q_bad : in_mem && in_bad)) || timeout;

  assign half_lane = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
  assign byte_lane = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign load_ext  = is_half ? {{(WIDTH-16){half_lane[15]}}, half_lane}
                   : is_byte ? {{(WIDTH-8){byte_lane[7]}}, byte_lane}
                   : bus.mem_rdata;

  // State register.
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
  end

  // Next state: memory ops enter ACCESS (or DONE directly when rejected), ack/timeout end ACCESS.
  always_comb begin
    state_d = state_q == IDLE   ? (q_mem  ? (q_bad  ? DONE : ACCESS)
                                : in_mem ? (in_bad ? DONE : ACCESS) : IDLE)
            : state_q == ACCESS ? ((bus.mem_ack || timeout) ? DONE : ACCESS)
            : IDLE;
  end

  // Outputs: stall and bubble while a transfer is pending, bus driven only in ACCESS.
  always_comb begin
    IsStall       = acc || (state_q == IDLE && q_mem);
    IR_out        = (state_q == DONE || (state_q == IDLE && !q_mem)) ? ir_q : NOP_IR;
    bus.mem_req   = acc;
    bus.mem_we    = acc && is_store;
    bus.mem_addr  = acc ? {addr_q[WIDTH-1:2], 2'b00} : '0;
    bus.mem_be    = !acc   ? 4'h0
                  : is_word ? 4'hF
                  : is_half ? (addr_q[1] ? 4'hC : 4'h3)
                  : 4'b0001 << addr_q[1:0];
    bus.mem_wdata = !acc   ? '0
                  : is_word ? z_q
                  : is_half ? {(WIDTH/16){z_q[15:0]}}
                  : {(WIDTH/8){z_q[7:0]}};
  end

  // Datapath registers: EXE capture, timeout counter, load data and the error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q   <= NOP_IR;
      pc_q   <= '0;
      z_q    <= '0;
      addr_q <= '0;
      lmd_q  <= '0;
      cnt_q  <= '0;
      berr_q <= 1'b0;
    end else begin
      if (accept) begin
        ir_q   <= IR_in;
        pc_q   <= PC_in;
        z_q    <= Z_in;
        addr_q <= Addr_in;
      end
      cnt_q  <= acc ? cnt_q + 8'd1 : 8'd0;
      if (acc && bus.mem_ack && is_load)
        lmd_q <= load_ext;
      else if (err_d)
        lmd_q <= '0;
      berr_q <= err_d;
    end
  end

  assign PC_out = pc_q;
  assign Z_out  = z_q;
  assign LMD    = lmd_q;
  assign BusErr = berr_q;
endmodule
